// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM states,
// the default reset PC and the branch-immediate sign extension.
package instr_fetch_unit_pkg;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_branch.sv
// Next-PC datapath: pc_in + 4, plus the sign-extended byte offset when
// nPC_sel selects the branch path. All arithmetic wraps modulo 2^32.
module pc_branch
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_in,
  input  logic [15:0] imm16,
  input  logic        nPC_sel,
  output logic [31:0] pc_out
);

  logic [31:0] offset;

  assign offset = nPC_sel ? sext16(imm16) : 32'd0;
  assign pc_out = pc_in + 32'd4 + offset;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one imem read in flight,
// and hands fetched words to decode through a single valid/ready slot.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm16,
  output logic [31:0] pc
);

  fetch_state_t state;
  logic         drop;
  logic         slot_free;
  logic         redirect;
  logic         req_hs;
  logic [31:0]  nb_pc_in;
  logic [15:0]  nb_imm16;
  logic [31:0]  pc_next;

  assign slot_free      = !if_valid || if_ready;
  assign redirect       = br_valid && br_taken;
  // rst_n gates the request so nothing is issued while reset is held.
  assign imem_req_valid = rst_n && (state == FETCH_REQ) && slot_free;
  assign imem_addr      = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign nb_pc_in = redirect ? br_pc : pc;
  assign nb_imm16 = redirect ? br_imm16 : 16'h0000;

  pc_branch u_pc_branch (
    .pc_in   (nb_pc_in),
    .imm16   (nb_imm16),
    .nPC_sel (redirect),
    .pc_out  (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
    end else if (redirect) begin
      pc       <= pc_next;
      if_valid <= 1'b0;
      case (state)
        FETCH_REQ: begin
          if (req_hs) begin
            state <= FETCH_WAIT;
            drop  <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          // A response this cycle is the stale one: swallow it now.
          if (imem_rsp_valid) begin
            state <= FETCH_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end else begin
      if (if_valid && if_ready) if_valid <= 1'b0;
      case (state)
        FETCH_REQ: begin
          if (req_hs) state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            state <= FETCH_REQ;
            if (drop) begin
              drop <= 1'b0;
            end else begin
              if_instr <= imem_rsp_data;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc_next;
            end
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each task drives one scenario and
// checks outputs 1 ns after the rising edge against hand-computed values.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = 32'd0;
  logic [15:0] br_imm16 = 16'd0;
  logic [31:0] pc;

  int total = 0;
  int bad = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .br_pc          (br_pc),
    .br_imm16       (br_imm16),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic taken, input logic [31:0] bpc, input logic [15:0] imm);
    br_valid = 1'b1;
    br_taken = taken;
    br_pc    = bpc;
    br_imm16 = imm;
  endtask

  task automatic branch_off();
    br_valid = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (pc !== 32'h0040_0020) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0040_0020); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'd0) begin bad++; $display("FAIL reset_if_instr got=%h exp=0", if_instr); end
    total++; if (if_pc !== 32'd0) begin bad++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0020) begin bad++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, 32'h0040_0020); end
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL wait_no_req got=%b exp=0", imem_req_valid); end
    respond(32'h2008_0005);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0020 || if_instr !== 32'h2008_0005) begin bad++; $display("FAIL first_fill got=%b/%h/%h exp=1/00400020/20080005", if_valid, if_pc, if_instr); end
    total++; if (pc !== 32'h0040_0024) begin bad++; $display("FAIL first_pc got=%h exp=00400024", pc); end
    $display("fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_backpressure();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_block got=%b exp=0", imem_req_valid); end
    tick();
    tick();
    total++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || pc !== 32'h0040_0024) begin bad++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/00400024", imem_req_valid, if_valid, pc); end
    if_ready = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0024) begin bad++; $display("FAIL bp_release got=%b/%h exp=1/00400024", imem_req_valid, imem_addr); end
    tick();
    if_ready = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL bp_consume got=%b exp=0", if_valid); end
    respond(32'h1111_1111);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0024 || if_instr !== 32'h1111_1111 || pc !== 32'h0040_0028) begin bad++; $display("FAIL bp_fill got=%b/%h/%h/%h exp=1/00400024/11111111/00400028", if_valid, if_pc, if_instr, pc); end
    $display("fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_branch_in_wait();
    if_ready = 1'b1;
    branch(1'b0, 32'h1234_5678, 16'h4444);
    tick();
    if_ready = 1'b0;
    total++; if (pc !== 32'h0040_0028) begin bad++; $display("FAIL not_taken_pc got=%h exp=00400028", pc); end
    branch(1'b1, 32'h0040_0028, 16'hFFF8);
    tick();
    branch_off();
    total++; if (pc !== 32'h0040_0024 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL wait_redirect got=%h/%b exp=00400024/0", pc, imem_req_valid); end
    respond(32'hDEAD_BEEF);
    total++; if (if_valid !== 1'b0 || pc !== 32'h0040_0024) begin bad++; $display("FAIL wait_drop got=%b/%h exp=0/00400024", if_valid, pc); end
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0024) begin bad++; $display("FAIL wait_refetch got=%b/%h exp=1/00400024", imem_req_valid, imem_addr); end
  endtask

  task automatic test_branch_at_handshake();
    branch(1'b1, 32'h0040_0030, 16'h0010);
    tick();
    branch_off();
    total++; if (pc !== 32'h0040_0044 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL hs_redirect got=%h/%b exp=00400044/0", pc, imem_req_valid); end
    respond(32'hCAFE_0000);
    total++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0044) begin bad++; $display("FAIL hs_drop got=%b/%b/%h exp=0/1/00400044", if_valid, imem_req_valid, imem_addr); end
    tick();
    respond(32'hAAAA_0001);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0044 || if_instr !== 32'hAAAA_0001 || pc !== 32'h0040_0048) begin bad++; $display("FAIL hs_fill got=%b/%h/%h/%h exp=1/00400044/aaaa0001/00400048", if_valid, if_pc, if_instr, pc); end
    $display("fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_redirect_flush();
    branch(1'b1, 32'h0040_1000, 16'h0100);
    respond(32'h5555_5555);
    branch_off();
    total++; if (if_valid !== 1'b0 || pc !== 32'h0040_1104) begin bad++; $display("FAIL flush_slot got=%b/%h exp=0/00401104", if_valid, pc); end
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_1104) begin bad++; $display("FAIL flush_refetch got=%b/%h exp=1/00401104", imem_req_valid, imem_addr); end
    tick();
    branch(1'b1, 32'h0040_2000, 16'h8000);
    respond(32'h6666_6666);
    branch_off();
    total++; if (if_valid !== 1'b0 || pc !== 32'h003F_A004 || imem_req_valid !== 1'b1 || imem_addr !== 32'h003F_A004) begin bad++; $display("FAIL rsp_redirect got=%b/%h/%b/%h exp=0/003fa004/1/003fa004", if_valid, pc, imem_req_valid, imem_addr); end
    tick();
    respond(32'h7777_7777);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h003F_A004 || if_instr !== 32'h7777_7777 || pc !== 32'h003F_A008) begin bad++; $display("FAIL rsp_redirect_fill got=%b/%h/%h/%h exp=1/003fa004/77777777/003fa008", if_valid, if_pc, if_instr, pc); end
    $display("fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  task automatic test_reset_mid_and_wrap();
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pc !== 32'h0040_0020 || if_valid !== 1'b0 || if_pc !== 32'd0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL midreset got=%h/%b/%h/%b exp=00400020/0/0/0", pc, if_valid, if_pc, imem_req_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0020) begin bad++; $display("FAIL midreset_req got=%b/%h exp=1/00400020", imem_req_valid, imem_addr); end
    tick();
    respond(32'h9999_9999);
    total++; if (if_valid !== 1'b0 || pc !== 32'h0040_0020 || imem_addr !== 32'h0040_0020) begin bad++; $display("FAIL late_rsp got=%b/%h/%h exp=0/00400020/00400020", if_valid, pc, imem_addr); end
    imem_req_ready = 1'b1;
    tick();
    respond(32'h1234_5678);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0020 || if_instr !== 32'h1234_5678 || pc !== 32'h0040_0024) begin bad++; $display("FAIL restart_fill got=%b/%h/%h/%h exp=1/00400020/12345678/00400024", if_valid, if_pc, if_instr, pc); end
    branch(1'b1, 32'hFFFF_FFF8, 16'h0000);
    tick();
    branch_off();
    total++; if (pc !== 32'hFFFF_FFFC || if_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target got=%h/%b/%h exp=fffffffc/0/fffffffc", pc, if_valid, imem_addr); end
    tick();
    respond(32'h0F0F_0F0F);
    total++; if (pc !== 32'd0 || if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_seq got=%h/%h/%b/%h exp=0/fffffffc/1/0", pc, if_pc, if_valid, imem_addr); end
    $display("fetch pc=%h instr=%h", if_pc, if_instr);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_branch_in_wait();
    test_branch_at_handshake();
    test_redirect_flush();
    test_reset_mid_and_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
